// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Request sequencer in front of the 32x8 data memory (combinational read,
// synchronous write on mem_en). The core issues LOAD / STORE / INC / SWAP
// requests over a valid/ready handshake. Each request is sequenced as
// IDLE -> EXEC -> RESP, and the response is returned from registers. Writes
// into the constant window [RO_LO, RO_HI] are suppressed and flagged on
// rsp_err.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready     request handshake
//   req_op                  00 LOAD, 01 STORE, 10 INC, 11 SWAP
//   req_addr, req_wdata     request address and store/swap data
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                pre-operation memory value (8'h00 for STORE)
//   rsp_err                 write suppressed by protection
//   mem_en/mem_addr/
//   mem_wdata/mem_rdata     memory interface
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | ready for a request; latches op/addr/wdata on req_valid
// S_EXEC | one-cycle memory access; write issued here, response captured
// S_RESP | response held until rsp_ready
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter logic [4:0] RO_LO      = 5'h1B,
   parameter logic [4:0] RO_HI      = 5'h1C,
   parameter bit         PROTECT_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [4:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       mem_en,
   output logic [4:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_INC   = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [1:0] r_op;
   logic [4:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_data;
   logic       r_rsp_err;

   logic       w_prot;
   logic       w_req_ready;
   logic       w_mem_en;
   logic [7:0] w_mem_wdata;
   logic       w_accept;
   logic       w_exec;
   logic       w_consume;

   // Unsigned inclusive window compare on the latched address.
   assign w_prot = PROTECT_EN && (r_addr >= RO_LO) && (r_addr <= RO_HI);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_mem_en    = 1'b0;
      w_mem_wdata = 8'h00;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      w_consume   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // State already sits in IDLE during reset; gate ready explicitly.
            w_req_ready = !reset;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_exec   = 1'b1;
            w_mem_en = (r_op != OP_LOAD) && !w_prot;
            case (r_op)
               OP_STORE: w_mem_wdata = r_wdata;
               OP_SWAP:  w_mem_wdata = r_wdata;
               OP_INC:   w_mem_wdata = mem_rdata + 8'd1;
               default:  w_mem_wdata = 8'h00;
            endcase
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_consume   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_op        <= 2'b00;
         r_addr      <= 5'h00;
         r_wdata     <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_exec) begin
            // A protected write still reports the value read from memory.
            r_rsp_data  <= (r_op == OP_STORE) ? 8'h00 : mem_rdata;
            r_rsp_err   <= w_prot && (r_op != OP_LOAD);
            r_rsp_valid <= 1'b1;
         end
         if (w_consume) begin
            // rsp_data intentionally keeps its last value.
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
         end
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign mem_en    = w_mem_en;
   assign mem_addr  = r_addr;
   assign mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controllers share one request stream: instance 0 with write protection,
// instance 1 with PROTECT_EN = 0. Each drives its own 32x8 memory. A
// transaction-level model of the memory contents predicts every response,
// memory-port value and final memory contents.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

   localparam logic [1:0] LOAD  = 2'b00;
   localparam logic [1:0] STORE = 2'b01;
   localparam logic [1:0] INC   = 2'b10;
   localparam logic [1:0] SWAP  = 2'b11;

   logic       clock;
   logic       reset;
   logic       mem_rst;
   logic       req_valid;
   logic [1:0] req_op;
   logic [4:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_ready;

   logic [1:0] req_ready_v;
   logic [1:0] rsp_valid_v;
   logic [1:0] rsp_err_v;
   logic [1:0] mem_en_v;
   logic [7:0] rsp_data_v  [2];
   logic [4:0] mem_addr_v  [2];
   logic [7:0] mem_wdata_v [2];
   logic [7:0] mem_rdata_v [2];

   logic [7:0] mem0 [32];
   logic [7:0] mem1 [32];

   logic [7:0] model [2][32];

   int checks;
   int failures;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   data_mem_ctrl #(.RO_LO(5'h1B), .RO_HI(5'h1C), .PROTECT_EN(1'b1)) dut0 (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready_v[0]),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid_v[0]),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data_v[0]),
      .rsp_err   (rsp_err_v[0]),
      .mem_en    (mem_en_v[0]),
      .mem_addr  (mem_addr_v[0]),
      .mem_wdata (mem_wdata_v[0]),
      .mem_rdata (mem_rdata_v[0])
   );

   data_mem_ctrl #(.RO_LO(5'h1B), .RO_HI(5'h1C), .PROTECT_EN(1'b0)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready_v[1]),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid_v[1]),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data_v[1]),
      .rsp_err   (rsp_err_v[1]),
      .mem_en    (mem_en_v[1]),
      .mem_addr  (mem_addr_v[1]),
      .mem_wdata (mem_wdata_v[1]),
      .mem_rdata (mem_rdata_v[1])
   );

   // Memories: constants at 0x1B/0x1C loaded once at power-up only, so that a
   // controller reset does not disturb memory contents.
   always @(posedge clock or posedge mem_rst) begin
      if (mem_rst) begin
         for (int i = 0; i < 32; i++) mem0[i] <= (i == 27) ? 8'hFF : (i == 28) ? 8'hAA : 8'h00;
      end else if (mem_en_v[0]) begin
         mem0[mem_addr_v[0]] <= mem_wdata_v[0];
      end
   end

   always @(posedge clock or posedge mem_rst) begin
      if (mem_rst) begin
         for (int i = 0; i < 32; i++) mem1[i] <= (i == 27) ? 8'hFF : (i == 28) ? 8'hAA : 8'h00;
      end else if (mem_en_v[1]) begin
         mem1[mem_addr_v[1]] <= mem_wdata_v[1];
      end
   end

   assign mem_rdata_v[0] = mem0[mem_addr_v[0]];
   assign mem_rdata_v[1] = mem1[mem_addr_v[1]];

   function automatic logic [7:0] mem_at(input int d, input logic [4:0] a);
      return (d == 0) ? mem0[a] : mem1[a];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full request with the response stalled for 'stall' cycles.
   task automatic txn(input logic [1:0] op, input logic [4:0] addr,
                      input logic [7:0] wd, input int stall);
      logic       prot    [2];
      logic [7:0] old     [2];
      logic [7:0] exp_rsp [2];
      logic       exp_err [2];
      logic       exp_en  [2];
      logic [7:0] exp_wd  [2];
      @(negedge clock);
      for (int d = 0; d < 2; d++)
         check($sformatf("d%0d idle req_ready", d), 32'(req_ready_v[d]), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      rsp_ready = (stall == 0);
      @(posedge clock);
      #1;
      // Inputs are don't-care now; drive noise that must be ignored.
      req_valid = 1'b1;
      req_op    = 2'($urandom_range(0, 3));
      req_addr  = 5'($urandom_range(0, 31));
      req_wdata = 8'($urandom_range(0, 255));
      for (int d = 0; d < 2; d++) begin
         prot[d]    = (d == 0) && (addr >= 5'h1B) && (addr <= 5'h1C);
         old[d]     = model[d][addr];
         exp_en[d]  = (op != LOAD) && !prot[d];
         exp_err[d] = prot[d] && (op != LOAD);
         exp_rsp[d] = (op == STORE) ? 8'h00 : old[d];
         exp_wd[d]  = (op == INC) ? 8'(old[d] + 8'd1) : wd;
         if (exp_en[d]) model[d][addr] = exp_wd[d];
         check($sformatf("d%0d exec mem_en", d), 32'(mem_en_v[d]), 32'(exp_en[d]));
         check($sformatf("d%0d exec mem_addr", d), 32'(mem_addr_v[d]), 32'(addr));
         if (op != LOAD)
            check($sformatf("d%0d exec mem_wdata", d), 32'(mem_wdata_v[d]), 32'(exp_wd[d]));
         check($sformatf("d%0d exec req_ready", d), 32'(req_ready_v[d]), 32'd0);
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d rsp_valid", d), 32'(rsp_valid_v[d]), 32'd1);
         check($sformatf("d%0d rsp_data", d), 32'(rsp_data_v[d]), 32'(exp_rsp[d]));
         check($sformatf("d%0d rsp_err", d), 32'(rsp_err_v[d]), 32'(exp_err[d]));
         check($sformatf("d%0d resp mem_en", d), 32'(mem_en_v[d]), 32'd0);
         check($sformatf("d%0d resp mem_wdata", d), 32'(mem_wdata_v[d]), 32'd0);
         check($sformatf("d%0d resp mem_addr", d), 32'(mem_addr_v[d]), 32'(addr));
         check($sformatf("d%0d memory", d), 32'(mem_at(d, addr)), 32'(model[d][addr]));
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clock);
         #1;
         for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d stall rsp_valid", d), 32'(rsp_valid_v[d]), 32'd1);
            check($sformatf("d%0d stall rsp_data", d), 32'(rsp_data_v[d]), 32'(exp_rsp[d]));
            check($sformatf("d%0d stall rsp_err", d), 32'(rsp_err_v[d]), 32'(exp_err[d]));
            check($sformatf("d%0d stall req_ready", d), 32'(req_ready_v[d]), 32'd0);
            check($sformatf("d%0d stall mem_en", d), 32'(mem_en_v[d]), 32'd0);
         end
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d done rsp_valid", d), 32'(rsp_valid_v[d]), 32'd0);
         check($sformatf("d%0d done rsp_err", d), 32'(rsp_err_v[d]), 32'd0);
         check($sformatf("d%0d done rsp_data held", d), 32'(rsp_data_v[d]), 32'(exp_rsp[d]));
         check($sformatf("d%0d done req_ready", d), 32'(req_ready_v[d]), 32'd1);
      end
   endtask

   initial begin
      logic [1:0] r_op;
      logic [4:0] r_addr;
      logic [7:0] r_wd;
      int         r_stall;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      mem_rst   = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = 5'h00;
      req_wdata = 8'h00;
      rsp_ready = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 32; a++)
            model[d][a] = (a == 27) ? 8'hFF : (a == 28) ? 8'hAA : 8'h00;

      // Reset state, with a request offered that must not be taken.
      req_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d rst req_ready", d), 32'(req_ready_v[d]), 32'd0);
         check($sformatf("d%0d rst rsp_valid", d), 32'(rsp_valid_v[d]), 32'd0);
         check($sformatf("d%0d rst rsp_data", d), 32'(rsp_data_v[d]), 32'd0);
         check($sformatf("d%0d rst rsp_err", d), 32'(rsp_err_v[d]), 32'd0);
         check($sformatf("d%0d rst mem_en", d), 32'(mem_en_v[d]), 32'd0);
         check($sformatf("d%0d rst mem_addr", d), 32'(mem_addr_v[d]), 32'd0);
         check($sformatf("d%0d rst mem_wdata", d), 32'(mem_wdata_v[d]), 32'd0);
      end
      req_valid = 1'b0;
      @(negedge clock);
      reset   = 1'b0;
      mem_rst = 1'b0;

      // Store then load back.
      txn(STORE, 5'h05, 8'h3C, 0);
      txn(LOAD,  5'h05, 8'h00, 0);
      // Constant window.
      txn(LOAD,  5'h1B, 8'h00, 0);
      txn(LOAD,  5'h1C, 8'h00, 0);
      txn(STORE, 5'h1C, 8'h11, 0);
      txn(LOAD,  5'h1C, 8'h00, 0);
      check("d0 const 0x1C kept", 32'(mem0[28]), 32'hAA);
      // Increment wrap.
      txn(STORE, 5'h02, 8'hFF, 0);
      txn(INC,   5'h02, 8'h00, 0);
      check("d0 inc wrap", 32'(mem0[2]), 32'h00);
      txn(INC,   5'h02, 8'h00, 0);
      check("d0 inc again", 32'(mem0[2]), 32'h01);
      // Swap, and swap into the window (unprotected instance writes it).
      txn(SWAP,  5'h1F, 8'h5A, 0);
      check("d0 swap mem", 32'(mem0[31]), 32'h5A);
      txn(SWAP,  5'h1B, 8'h77, 0);
      check("d1 swap unprotected", 32'(mem1[27]), 32'h77);
      check("d0 swap protected", 32'(mem0[27]), 32'hFF);
      // Response back-pressure.
      txn(LOAD,  5'h05, 8'h00, 4);

      // Reset during EXEC of a store: no write may land.
      @(negedge clock);
      req_valid = 1'b1;
      req_op    = STORE;
      req_addr  = 5'h07;
      req_wdata = 8'h99;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      for (int d = 0; d < 2; d++)
         check($sformatf("d%0d pre-rst mem_en", d), 32'(mem_en_v[d]), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d midrst mem_en", d), 32'(mem_en_v[d]), 32'd0);
         check($sformatf("d%0d midrst rsp_valid", d), 32'(rsp_valid_v[d]), 32'd0);
         check($sformatf("d%0d midrst req_ready", d), 32'(req_ready_v[d]), 32'd0);
         check($sformatf("d%0d midrst mem_wdata", d), 32'(mem_wdata_v[d]), 32'd0);
      end
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d postrst req_ready", d), 32'(req_ready_v[d]), 32'd1);
         check($sformatf("d%0d postrst rsp_valid", d), 32'(rsp_valid_v[d]), 32'd0);
         check($sformatf("d%0d postrst rsp_data", d), 32'(rsp_data_v[d]), 32'd0);
         check($sformatf("d%0d no write 0x07", d), 32'(mem_at(d, 5'h07)), 32'h00);
      end
      txn(LOAD, 5'h07, 8'h00, 0);

      // Randomized traffic, biased toward the protection boundaries.
      for (int n = 0; n < 150; n++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(26, 29))
                                               : 5'($urandom_range(0, 31));
         r_wd   = 8'($urandom_range(0, 255));
         r_stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         txn(r_op, r_addr, r_wd, r_stall);
      end

      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 32; a++)
            check($sformatf("d%0d final mem[%0d]", d, a), 32'(mem_at(d, 5'(a))), 32'(model[d][a]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
